// File: rtl/btn_debounce.sv
// Per-button two-FF synchroniser and debounce FSM with optional hold-to-repeat.
// Emits clean levels plus single-cycle press/release pulses for user logic.
module btn_debounce #(
    parameter int unsigned N_BTN     = 5,
    parameter logic [31:0] LIMIT     = 32'd1250000,
    parameter logic        REPEAT_EN = 1'b0,
    parameter logic [31:0] HOLD      = 32'd50000000,
    parameter logic [31:0] REPEAT    = 32'd12500000
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } state_e;

    state_e      state_q [N_BTN];
    state_e      state_d [N_BTN];
    logic [31:0] ctr_q   [N_BTN];
    logic [31:0] ctr_d   [N_BTN];

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] rep_q;
    logic [N_BTN-1:0] rep_d;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] release_d;
    logic             any_q;

    // Next-state logic for every button FSM; rep marks the REPEAT phase after the first HOLD expiry.
    always_comb begin
        for (int i = 0; i < int'(N_BTN); i++) begin
            state_d[i]   = state_q[i];
            ctr_d[i]     = ctr_q[i];
            rep_d[i]     = rep_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            case (state_q[i])
                ST_RELEASED: begin
                    ctr_d[i] = 32'd0;
                    if (sync2_q[i]) begin
                        state_d[i] = ST_PRESS_PEND;
                    end else begin
                        state_d[i] = ST_RELEASED;
                    end
                end
                ST_PRESS_PEND: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASED;
                        ctr_d[i]   = 32'd0;
                    end else if (ctr_q[i] == LIMIT - 32'd1) begin
                        state_d[i] = ST_PRESSED;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                        ctr_d[i]   = 32'd0;
                        rep_d[i]   = 1'b0;
                    end else begin
                        ctr_d[i] = ctr_q[i] + 32'd1;
                    end
                end
                ST_PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASE_PEND;
                        ctr_d[i]   = 32'd0;
                        rep_d[i]   = 1'b0;
                    end else if (!REPEAT_EN) begin
                        ctr_d[i] = 32'd0;
                    end else if (!rep_q[i] && (ctr_q[i] == HOLD - 32'd1)) begin
                        press_d[i] = 1'b1;
                        ctr_d[i]   = 32'd0;
                        rep_d[i]   = 1'b1;
                    end else if (rep_q[i] && (ctr_q[i] == REPEAT - 32'd1)) begin
                        press_d[i] = 1'b1;
                        ctr_d[i]   = 32'd0;
                    end else begin
                        ctr_d[i] = ctr_q[i] + 32'd1;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (sync2_q[i]) begin
                        // Bounce back up: hold timing starts over, no event.
                        state_d[i] = ST_PRESSED;
                        ctr_d[i]   = 32'd0;
                        rep_d[i]   = 1'b0;
                    end else if (ctr_q[i] == LIMIT - 32'd1) begin
                        state_d[i]   = ST_RELEASED;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                        ctr_d[i]     = 32'd0;
                    end else begin
                        ctr_d[i] = ctr_q[i] + 32'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                    ctr_d[i]   = 32'd0;
                    rep_d[i]   = 1'b0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Synchroniser, FSM state, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            rep_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                state_q[i] <= ST_RELEASED;
                ctr_q[i]   <= 32'd0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            rep_q     <= rep_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= |press_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                state_q[i] <= state_d[i];
                ctr_q[i]   <= ctr_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign any_press   = any_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce against a run-length reference model.
module tb_btn_debounce;

    localparam int N = 5;
    localparam int L = 500;
    localparam int H = 2000;
    localparam int R = 800;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_press;

    int n_cmp = 0;
    int n_err = 0;

    btn_debounce #(
        .N_BTN(N), .LIMIT(32'd500), .REPEAT_EN(1'b1), .HOLD(32'd2000), .REPEAT(32'd800)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a level flips after LIMIT+1 consecutive synchronised samples
    // opposing it; repeats fire HOLD, HOLD+REPEAT, ... cycles after an unbroken high run begins.
    logic [N-1:0] m_s1, m_s2, m_level, e_press, e_release;
    logic [N-1:0] hvalid;
    int           run [N];
    int           k   [N];
    int           cyc = 0;
    int           cnt_press [N];
    int           cnt_rel   [N];
    int           log3 [$];

    task automatic model_step();
        logic s;
        e_press   = '0;
        e_release = '0;
        if (reset_in) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; hvalid = '0;
            for (int i = 0; i < N; i++) begin run[i] = 0; k[i] = 0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                s = m_s2[i];
                if (s != m_level[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == L + 1) begin
                    run[i]     = 0;
                    m_level[i] = s;
                    if (s) begin e_press[i] = 1'b1; hvalid[i] = 1'b1; k[i] = 0; end
                    else begin e_release[i] = 1'b1; hvalid[i] = 1'b0; end
                end else if (m_level[i]) begin
                    if (!s) hvalid[i] = 1'b0;
                    else if (!hvalid[i]) begin hvalid[i] = 1'b1; k[i] = 0; end
                    else begin
                        k[i]++;
                        if (k[i] == H || (k[i] > H && ((k[i] - H) % R) == 0)) e_press[i] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    endtask

    // Cycle-by-cycle scoreboard: outputs sampled on the falling edge.
    initial begin
        for (int i = 0; i < N; i++) begin cnt_press[i] = 0; cnt_rel[i] = 0; end
        forever begin
            @(posedge clk_in);
            model_step();
            cyc++;
            @(negedge clk_in);
            chk("outputs", {btn_level, btn_press, btn_release, any_press},
                {m_level, e_press, e_release, |e_press});
            for (int i = 0; i < N; i++) begin
                if (btn_press[i])   cnt_press[i]++;
                if (btn_release[i]) cnt_rel[i]++;
            end
            if (btn_press[3]) log3.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Edges from the first sampling edge E0 until the chosen pulse on bit b; -1 on timeout.
    task automatic wait_evt(input bit rel, input int b, output int lat);
        lat = -1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_in);
            #1;
            if ((rel ? btn_release[b] : btn_press[b]) === 1'b1) begin lat = c; break; end
        end
    endtask

    initial begin
        int lat, p0, r0, n_iter;
        reset_in = 1'b1;
        btn_raw  = 5'b11111;
        idle(5);
        chk("reset_outs", {btn_level, btn_press, btn_release, any_press}, 64'd0);

        // Release reset with bit0 held
        reset_in = 1'b0;
        btn_raw  = 5'b00001;
        wait_evt(1'b0, 0, lat);
        chk("rst_hold_lat", lat, 64'd502);
        idle(1);
        btn_raw = 5'b00000;
        wait_evt(1'b1, 0, lat);
        chk("rel0_lat", lat, 64'd502);
        idle(600);

        // Clean press on bit2
        btn_raw[2] = 1'b1;
        wait_evt(1'b0, 2, lat);
        chk("press2_lat", lat, 64'd502);
        chk("press2_any", {btn_level[2], any_press, btn_press}, {1'b1, 1'b1, 5'b00100});
        @(posedge clk_in); #1;
        chk("press2_width", {btn_press[2], any_press}, 64'd0);
        idle(300);
        btn_raw[2] = 1'b0;
        wait_evt(1'b1, 2, lat);
        chk("rel2_lat", lat, 64'd502);
        idle(600);

        // Bounce on bit1
        p0 = cnt_press[1];
        r0 = cnt_rel[1];
        for (int t = 0; t < 20; t++) begin
            btn_raw[1] = ~btn_raw[1];
            idle(100);
        end
        chk("bounce_quiet", cnt_press[1] - p0, 64'd0);
        btn_raw[1] = 1'b1;
        wait_evt(1'b0, 1, lat);
        chk("bounce_lat", lat, 64'd502);
        idle(300);
        chk("bounce_once", cnt_press[1] - p0, 64'd1);
        btn_raw[1] = 1'b0;
        idle(700);
        chk("bounce_rel", cnt_rel[1] - r0, 64'd1);

        // Simultaneous bits 0 and 4
        btn_raw = 5'b10001;
        wait_evt(1'b0, 0, lat);
        chk("simul_vec", {any_press, btn_press}, {1'b1, 5'b10001});
        @(posedge clk_in); #1;
        chk("simul_any_once", {any_press, btn_press}, 64'd0);
        idle(100);
        btn_raw = 5'b00000;
        idle(700);

        // Hold-to-repeat on bit3
        log3.delete();
        r0 = cnt_rel[3];
        btn_raw[3] = 1'b1;
        wait_evt(1'b0, 3, lat);
        chk("rep_first_lat", lat, 64'd502);
        idle(4497);
        btn_raw[3] = 1'b0;
        idle(700);
        chk("rep_count", log3.size(), 64'd5);
        if (log3.size() == 5) begin
            chk("rep_p2000", log3[1] - log3[0], 64'd2000);
            chk("rep_p2800", log3[2] - log3[0], 64'd2800);
            chk("rep_p3600", log3[3] - log3[0], 64'd3600);
            chk("rep_p4400", log3[4] - log3[0], 64'd4400);
        end
        chk("rep_one_rel", cnt_rel[3] - r0, 64'd1);

        // Glitch low during hold restarts the hold count
        btn_raw[3] = 1'b1;
        wait_evt(1'b0, 3, lat);
        idle(1000);
        btn_raw[3] = 1'b0;
        idle(100);
        btn_raw[3] = 1'b1;
        wait_evt(1'b0, 3, lat);
        chk("glitch_rehold", lat, 64'd2002);
        idle(10);
        btn_raw[3] = 1'b0;
        idle(700);

        // Reset mid PRESS_PEND with bit0 held
        p0 = cnt_press[0];
        btn_raw[0] = 1'b1;
        idle(302);
        reset_in = 1'b1;
        idle(1);
        reset_in = 1'b0;
        chk("midrst_nopulse", cnt_press[0] - p0, 64'd0);
        wait_evt(1'b0, 0, lat);
        chk("midrst_lat", lat, 64'd502);
        idle(10);
        btn_raw = 5'b00000;
        idle(700);

        // Random phase, scored by the model every cycle
        n_iter = 120;
        for (int it = 0; it < n_iter; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_in = 1'b1;
                idle($urandom_range(1, 3));
                reset_in = 1'b0;
            end
            btn_raw[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(500, 1500));
            else idle($urandom_range(1, 80));
        end
        btn_raw = 5'b00000;
        idle(800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
